// File: rtl/des_pkg.sv
// Shared constants, state encoding and CRC-8 step function for the DES output serializer.
package des_pkg;

    localparam int         BLOCK_BYTES_DEF = 8;
    localparam logic [7:0] CRC8_POLY       = 8'h07;

    typedef logic [1:0] ser_state_t;
    localparam ser_state_t ST_IDLE = 2'd0;
    localparam ser_state_t ST_LOAD = 2'd1;
    localparam ser_state_t ST_SEND = 2'd2;
    localparam ser_state_t ST_DONE = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [7:0] data;
    } tx_beat_t;

    // One byte through CRC-8 (MSB first, no reflection).
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/des_crc8.sv
// Byte-wide CRC-8 register with enable and synchronous clear.
// Only built when DES_OUT_CRC8_EN is defined.
`ifdef DES_OUT_CRC8_EN
module des_crc8
    import des_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] crc
);

    logic [7:0] crc_nxt;

    assign crc_nxt = crc8_next(crc, data);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            crc <= 8'h00;
        else if (clr)
            crc <= 8'h00;
        else if (en)
            crc <= crc_nxt;
    end

endmodule
`endif

// File: rtl/des_output_serializer.sv
// Captures a DES result block and streams it MSB byte first over valid/ready.
// DES_OUT_CRC8_EN appends a CRC-8 byte after the data bytes.
module des_output_serializer
    import des_pkg::*;
#(
    parameter int BLOCK_BYTES = BLOCK_BYTES_DEF
)(
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     data_out,
    input  logic [BLOCK_BYTES*8-1:0] des_result,
    input  logic                     tx_ready,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    output logic                     empty,
    output logic                     busy
);

    localparam int         W    = BLOCK_BYTES * 8;
    localparam logic [3:0] LAST = 4'(BLOCK_BYTES - 1);

    ser_state_t     state;
    logic [W-1:0]   shreg;
    logic [3:0]     cnt;
    logic           accept;
    logic           crc_phase;
    logic           send_done;
    tx_beat_t       beat;

    assign accept = tx_valid && tx_ready;

`ifdef DES_OUT_CRC8_EN
    logic [7:0] crc;

    // Counter parks at BLOCK_BYTES while the CRC byte is on the bus.
    assign crc_phase = (cnt == 4'(BLOCK_BYTES));
    assign send_done = accept && crc_phase;

    des_crc8 u_crc (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (state == ST_IDLE),
        .en    (accept && !crc_phase),
        .data  (shreg[W-1 -: 8]),
        .crc   (crc)
    );

    assign beat.data = crc_phase ? crc : shreg[W-1 -: 8];
`else
    assign crc_phase = 1'b0;
    assign send_done = accept && (cnt == LAST);
    assign beat.data = shreg[W-1 -: 8];
`endif

    assign beat.valid = (state == ST_SEND);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_out) begin
                        shreg <= des_result;
                        cnt   <= 4'd0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: state <= ST_SEND;
                ST_SEND: begin
                    if (accept && !crc_phase) begin
                        shreg <= shreg << 8;
                        cnt   <= cnt + 4'd1;
                    end
                    if (send_done)
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    // Hold until the controller drops its strobe so the same block is not recaptured.
                    if (!data_out)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign tx_valid = beat.valid;
    assign tx_byte  = beat.valid ? beat.data : 8'h00;
    assign empty    = ((state == ST_IDLE) && !data_out) || (state == ST_DONE);
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_des_output_serializer.sv
// Directed plus randomized bench for des_output_serializer with a byte-queue reference model.
module tb_des_output_serializer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        data_out;
    logic [63:0] des_result;
    logic        tx_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        empty;
    logic        busy;

    int total = 0;
    int bad   = 0;
    byte unsigned exp_q[$];

    always #5 clk = ~clk;

    des_output_serializer #(.BLOCK_BYTES(8)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .data_out   (data_out),
        .des_result (des_result),
        .tx_ready   (tx_ready),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .empty      (empty),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Expected byte stream: block bytes MSB first, plus a bitwise CRC-8 over the 64-bit message.
    function automatic void load_model(input logic [63:0] blk);
        logic [7:0] c;
        logic       fb;
        exp_q.delete();
        for (int i = 7; i >= 0; i--) exp_q.push_back(blk[i*8 +: 8]);
        c = 8'h00;
        for (int b = 63; b >= 0; b--) begin
            fb = c[7] ^ blk[b];
            c  = {c[6:0], 1'b0};
            if (fb) c = c ^ 8'h07;
        end
`ifdef DES_OUT_CRC8_EN
        exp_q.push_back(c);
`endif
    endfunction

    // mode 0: ready always; 1: ready pattern 1,0,0; 2: random ready and random data_out.
    task automatic stream(input int mode, input logic [63:0] drive_val, input int stop_after,
                          output int cycles);
        int n;
        int acc;
        byte unsigned e;
        n = 0;
        acc = 0;
        while (exp_q.size() > 0 && acc < stop_after && n < 300) begin
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (n % 3 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) data_out = 1'($urandom_range(0, 1));
            des_result = drive_val;
            chk("send_valid", tx_valid, 1);
            chk("send_busy", busy, 1);
            if (tx_ready) begin
                e = exp_q.pop_front();
                chk("byte", tx_byte, e);
                acc++;
            end else begin
                chk("stall_hold", tx_byte, exp_q[0]);
            end
            step();
            n++;
        end
        tx_ready = 1'b0;
        if (n >= 300) chk("stream_timeout", 1, 0);
        cycles = n;
    endtask

    task automatic run_block(input logic [63:0] blk, input int mode, input logic [63:0] drive_val,
                             input int done_hold);
        int sz;
        int cyc;
        data_out   = 1'b1;
        des_result = blk;
        load_model(blk);
        sz = exp_q.size();
        #1;
        chk("idle_strobe_empty", empty, 0);
        chk("idle_busy", busy, 0);
        step();
        tx_ready = 1'b1;
        chk("load_valid", tx_valid, 0);
        chk("load_busy", busy, 1);
        chk("load_empty", empty, 0);
        step();
        chk("latency_valid", tx_valid, 1);
        stream(mode, drive_val, 100, cyc);
        if (mode == 0) chk("consecutive", cyc, sz);
        data_out = 1'b1;
        #1;
        chk("done_empty", empty, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", tx_valid, 0);
        for (int i = 0; i < done_hold; i++) begin
            step();
            chk("hold_empty", empty, 1);
            chk("hold_busy", busy, 1);
            chk("hold_valid", tx_valid, 0);
        end
        data_out = 1'b0;
        #1;
        chk("fall_empty", empty, 1);
        step();
        chk("idle_busy_after", busy, 0);
        chk("idle_empty_after", empty, 1);
        chk("idle_valid_after", tx_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [63:0] rb;
        n_rst      = 1'b0;
        data_out   = 1'b0;
        tx_ready   = 1'b0;
        des_result = 64'h0;
        #12;
        chk("rst_valid", tx_valid, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_empty", empty, 1);
        n_rst = 1'b1;
        step();

        run_block(64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF, 0);
        run_block(64'h0123456789ABCDEF, 1, 64'h0123456789ABCDEF, 0);
        run_block(64'h0123456789ABCDEF, 0, 64'hFFFFFFFFFFFFFFFF, 0);

        // Reset after three accepted bytes.
        data_out   = 1'b1;
        des_result = 64'h0123456789ABCDEF;
        load_model(des_result);
        step();
        step();
        stream(0, des_result, 3, cyc);
        chk("pre_rst_valid", tx_valid, 1);
        n_rst    = 1'b0;
        data_out = 1'b0;
        #1;
        chk("midrst_valid", tx_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_byte", tx_byte, 0);
        step();
        n_rst = 1'b1;
        step();
        run_block(64'h0123456789ABCDEF, 0, 64'h0123456789ABCDEF, 0);

        run_block(64'hFEDCBA9876543210, 0, 64'hFEDCBA9876543210, 4);

        run_block(64'h0, 0, 64'h0, 0);
        run_block(64'h1, 1, 64'h1, 1);

        for (int k = 0; k < 6; k++) begin
            rb = {$urandom, $urandom};
            run_block(rb, 2, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
